// File: rtl/proto245s_chmux.sv
// proto245s_chmux: NCH-channel packet mux/demux sharing one FT245 sync link on ft_clk.
// Optional build macro PROTO245S_CHMUX_CSUM_EN appends/checks an XOR trailer word per frame.
module proto245s_chmux #(
    parameter int DATA_W  = 8,
    parameter int NCH     = 4,
    parameter int MAX_PKT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                    ft_clk_i,
    input  logic                    ft_rst_i,
    input  logic [NCH*CNT_W-1:0]    tx_count_i,
    input  logic [NCH*DATA_W-1:0]   tx_data_i,
    output logic [NCH-1:0]          tx_pop_o,
    output logic [DATA_W-1:0]       up_data_o,
    output logic                    up_valid_o,
    input  logic                    up_ready_i,
    input  logic [DATA_W-1:0]       dn_data_i,
    input  logic                    dn_valid_i,
    output logic                    dn_ready_o,
    output logic [DATA_W-1:0]       rx_data_o,
    output logic [NCH-1:0]          rx_valid_o,
    input  logic [NCH-1:0]          rx_ready_i,
    output logic                    rx_err_o
);

    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LEN_W = DATA_W + 1;
    localparam int CMP_W = (CNT_W > LEN_W) ? CNT_W : LEN_W;

    typedef enum logic [2:0] {
        T_IDLE    = 3'd0,
        T_HDR_ID  = 3'd1,
        T_HDR_LEN = 3'd2,
        T_PAYLOAD = 3'd3,
        T_TRAILER = 3'd4
    } tx_state_t;

    typedef enum logic [1:0] {
        R_ID   = 2'd0,
        R_LEN  = 2'd1,
        R_PAY  = 2'd2,
        R_CSUM = 2'd3
    } rx_state_t;

    function automatic logic [DATA_W-1:0] csum_fold(input logic [DATA_W-1:0] acc,
                                                    input logic [DATA_W-1:0] word);
        return acc ^ word;
    endfunction

    tx_state_t          tx_state_q, tx_state_d;
    logic [CH_W-1:0]    ch_q, ch_d, rr_q, rr_d;
    logic [LEN_W-1:0]   len_q, len_d, tx_rem_q, tx_rem_d;
    logic [DATA_W-1:0]  tx_csum_q, tx_csum_d;

    rx_state_t          rx_state_q, rx_state_d;
    logic [DATA_W-1:0]  id_q, id_d;
    logic [LEN_W-1:0]   rx_rem_q, rx_rem_d;
    logic [DATA_W-1:0]  rx_csum_q, rx_csum_d;
    logic               run_q;

    logic               pick_found_s;
    logic [CH_W-1:0]    pick_ch_s;
    logic [LEN_W-1:0]   pick_len_s;
    logic [DATA_W-1:0]  head_s;
    logic [DATA_W-1:0]  up_data_s;
    logic               up_valid_s;
    logic [NCH-1:0]     tx_pop_s;
    logic               id_bad_s;
    logic [CH_W-1:0]    id_ch_s;
    logic               dn_ready_s;
    logic [NCH-1:0]     rx_valid_s;
    logic [DATA_W-1:0]  rx_data_s;
    logic               rx_err_s;

    assign head_s   = tx_data_i[int'(ch_q)*DATA_W +: DATA_W];
    assign id_bad_s = (LEN_W'(id_q) >= LEN_W'(NCH));
    assign id_ch_s  = id_q[CH_W-1:0];

    // Round-robin search from rr+1; iterating downwards lets the nearest hit win.
    always_comb begin
        int               idx;
        logic [CMP_W-1:0] cnt;
        logic             hit;
        idx          = 0;
        cnt          = '0;
        hit          = 1'b0;
        pick_found_s = 1'b0;
        pick_ch_s    = rr_q;
        pick_len_s   = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx          = (int'(rr_q) + k) % NCH;
            cnt          = CMP_W'(tx_count_i[idx*CNT_W +: CNT_W]);
            hit          = (cnt != '0);
            pick_found_s = pick_found_s | hit;
            pick_ch_s    = hit ? CH_W'(idx) : pick_ch_s;
            pick_len_s   = hit ? ((cnt > CMP_W'(MAX_PKT)) ? LEN_W'(MAX_PKT) : LEN_W'(cnt))
                               : pick_len_s;
        end
    end

    // TX framer next-state and upstream outputs.
    always_comb begin
        tx_state_d = tx_state_q;
        ch_d       = ch_q;
        rr_d       = rr_q;
        len_d      = len_q;
        tx_rem_d   = tx_rem_q;
        tx_csum_d  = tx_csum_q;
        up_valid_s = 1'b0;
        up_data_s  = '0;
        tx_pop_s   = '0;
        case (tx_state_q)
            T_IDLE: begin
                if (pick_found_s) begin
                    tx_state_d = T_HDR_ID;
                    ch_d       = pick_ch_s;
                    rr_d       = pick_ch_s;
                    len_d      = pick_len_s;
                    tx_rem_d   = pick_len_s;
                end else begin
                    tx_state_d = T_IDLE;
                end
            end
            T_HDR_ID: begin
                up_valid_s = 1'b1;
                up_data_s  = DATA_W'(ch_q);
                if (up_ready_i) begin
                    tx_state_d = T_HDR_LEN;
                    tx_csum_d  = up_data_s;
                end else begin
                    tx_state_d = T_HDR_ID;
                end
            end
            T_HDR_LEN: begin
                up_valid_s = 1'b1;
                up_data_s  = DATA_W'(len_q - LEN_W'(1));
                if (up_ready_i) begin
                    tx_state_d = T_PAYLOAD;
                    tx_csum_d  = csum_fold(tx_csum_q, up_data_s);
                end else begin
                    tx_state_d = T_HDR_LEN;
                end
            end
            T_PAYLOAD: begin
                up_valid_s = 1'b1;
                up_data_s  = head_s;
                if (up_ready_i) begin
                    tx_pop_s  = NCH'(1'b1) << ch_q;
                    tx_csum_d = csum_fold(tx_csum_q, head_s);
                    tx_rem_d  = tx_rem_q - LEN_W'(1);
                    if (tx_rem_q == LEN_W'(1)) begin
`ifdef PROTO245S_CHMUX_CSUM_EN
                        tx_state_d = T_TRAILER;
`else
                        tx_state_d = T_IDLE;
`endif
                    end else begin
                        tx_state_d = T_PAYLOAD;
                    end
                end else begin
                    tx_state_d = T_PAYLOAD;
                end
            end
`ifdef PROTO245S_CHMUX_CSUM_EN
            T_TRAILER: begin
                up_valid_s = 1'b1;
                up_data_s  = tx_csum_q;
                if (up_ready_i) begin
                    tx_state_d = T_IDLE;
                end else begin
                    tx_state_d = T_TRAILER;
                end
            end
`endif
            default: tx_state_d = T_IDLE;
        endcase
    end

    // RX parser next-state; payload is a zero-latency pass-through to the addressed channel.
    always_comb begin
        rx_state_d = rx_state_q;
        id_d       = id_q;
        rx_rem_d   = rx_rem_q;
        rx_csum_d  = rx_csum_q;
        dn_ready_s = 1'b0;
        rx_valid_s = '0;
        rx_data_s  = '0;
        rx_err_s   = 1'b0;
        case (rx_state_q)
            R_ID: begin
                dn_ready_s = run_q;
                if (dn_valid_i && run_q) begin
                    id_d       = dn_data_i;
                    rx_csum_d  = dn_data_i;
                    rx_state_d = R_LEN;
                end else begin
                    rx_state_d = R_ID;
                end
            end
            R_LEN: begin
                dn_ready_s = 1'b1;
                if (dn_valid_i) begin
                    rx_rem_d   = LEN_W'(dn_data_i) + LEN_W'(1);
                    rx_csum_d  = csum_fold(rx_csum_q, dn_data_i);
                    rx_state_d = R_PAY;
                end else begin
                    rx_state_d = R_LEN;
                end
            end
            R_PAY: begin
                if (id_bad_s) begin
                    dn_ready_s = 1'b1;
                end else begin
                    dn_ready_s = rx_ready_i[id_ch_s];
                    rx_valid_s = NCH'(dn_valid_i) << id_ch_s;
                    rx_data_s  = dn_data_i;
                end
                if (dn_valid_i && dn_ready_s) begin
                    rx_rem_d  = rx_rem_q - LEN_W'(1);
                    rx_csum_d = csum_fold(rx_csum_q, dn_data_i);
                    if (rx_rem_q == LEN_W'(1)) begin
`ifdef PROTO245S_CHMUX_CSUM_EN
                        rx_state_d = R_CSUM;
`else
                        rx_state_d = R_ID;
                        rx_err_s   = id_bad_s;
`endif
                    end else begin
                        rx_state_d = R_PAY;
                    end
                end else begin
                    rx_state_d = R_PAY;
                end
            end
`ifdef PROTO245S_CHMUX_CSUM_EN
            R_CSUM: begin
                dn_ready_s = 1'b1;
                if (dn_valid_i) begin
                    rx_state_d = R_ID;
                    rx_err_s   = id_bad_s || (dn_data_i != rx_csum_q);
                end else begin
                    rx_state_d = R_CSUM;
                end
            end
`endif
            default: rx_state_d = R_ID;
        endcase
    end

    // TX state and frame context registers.
    always_ff @(posedge ft_clk_i or negedge ft_rst_i) begin
        if (!ft_rst_i) begin
            tx_state_q <= T_IDLE;
            ch_q       <= '0;
            rr_q       <= '0;
            len_q      <= '0;
            tx_rem_q   <= '0;
            tx_csum_q  <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            ch_q       <= ch_d;
            rr_q       <= rr_d;
            len_q      <= len_d;
            tx_rem_q   <= tx_rem_d;
            tx_csum_q  <= tx_csum_d;
        end
    end

    // RX state registers; run_q keeps dn_ready low until the first cycle out of reset.
    always_ff @(posedge ft_clk_i or negedge ft_rst_i) begin
        if (!ft_rst_i) begin
            rx_state_q <= R_ID;
            id_q       <= '0;
            rx_rem_q   <= '0;
            rx_csum_q  <= '0;
            run_q      <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            id_q       <= id_d;
            rx_rem_q   <= rx_rem_d;
            rx_csum_q  <= rx_csum_d;
            run_q      <= 1'b1;
        end
    end

    assign tx_pop_o   = tx_pop_s;
    assign up_data_o  = up_data_s;
    assign up_valid_o = up_valid_s;
    assign dn_ready_o = dn_ready_s;
    assign rx_data_o  = rx_data_s;
    assign rx_valid_o = rx_valid_s;
    assign rx_err_o   = rx_err_s;

endmodule
